log2_scan: RTL and testbench

//  Multi-cycle, parametrised leading/trailing-one detector with valid/ready handshakes on both sides.

---
 rtl/log2_scan_if.sv | 25 ++
 rtl/log2_scan.sv | 114 +++++++++++
 tb/tb_log2_scan.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/log2_scan_if.sv
// Request/response bus of the sequential leading/trailing-one detector.
// The master side issues vectors and takes results; the slave side is the detector.
interface log2_scan_if #(
  parameter int unsigned BIN_SIZE  = 32,
  parameter int unsigned BOUT_SIZE = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BIN_SIZE-1:0]  in_vector;
  logic                 in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [BOUT_SIZE-1:0] out_number;
  logic                 out_zero;

  modport master (
    output in_valid, in_vector, in_mode, out_ready,
    input  in_ready, out_valid, out_number, out_zero
  );

  modport slave (
    input  in_valid, in_vector, in_mode, out_ready,
    output in_ready, out_valid, out_number, out_zero
  );
endinterface

// File: rtl/log2_scan.sv
// Multi-cycle leading/trailing-one detector: scans CHUNK bits per cycle and
// returns the highest (mode 0) or lowest (mode 1) set bit index, plus a zero flag.
module log2_scan #(
  parameter int unsigned BIN_SIZE  = 32,
  parameter int unsigned BOUT_SIZE = 5,
  parameter int unsigned CHUNK     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  log2_scan_if.slave  bus
);
  localparam int unsigned NCHUNK = BIN_SIZE / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CW     = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  if (BOUT_SIZE < $clog2(BIN_SIZE)) begin : g_bad_bout
    $error("log2_scan: BOUT_SIZE too small for BIN_SIZE");
  end
  if ((BIN_SIZE % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_chunk
    $error("log2_scan: BIN_SIZE must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e               state_q, state_d;
  logic [BIN_SIZE-1:0]  vec_q, vec_d;
  logic                 mode_q, mode_d;
  logic [KW-1:0]        k_q, k_d;
  logic [BOUT_SIZE-1:0] number_q, number_d;
  logic                 zero_q, zero_d;

  logic [KW-1:0]        idx_c;
  logic [CHUNK-1:0]     chunk_c;
  logic [CW-1:0]        bit_c;
  logic [BOUT_SIZE-1:0] number_c;

  // Chunk under inspection: top-down for mode 0, bottom-up for mode 1.
  always_comb begin
    idx_c   = mode_q ? k_q : (KW'(NCHUNK - 1) - k_q);
    chunk_c = '0;
    for (int unsigned c = 0; c < NCHUNK; c++) begin
      if (idx_c == KW'(c)) chunk_c = vec_q[c*CHUNK +: CHUNK];
    end
  end

  // Priority pick inside the chunk; later loop hits override earlier ones.
  always_comb begin
    bit_c = '0;
    for (int unsigned b = 0; b < CHUNK; b++) begin
      if (!mode_q && chunk_c[b])           bit_c = CW'(b);
      if (mode_q && chunk_c[CHUNK-1-b])    bit_c = CW'(CHUNK - 1 - b);
    end
    number_c = BOUT_SIZE'(idx_c) * BOUT_SIZE'(CHUNK) + BOUT_SIZE'(bit_c);
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    mode_d   = mode_q;
    k_d      = k_q;
    number_d = number_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          vec_d   = bus.in_vector;
          mode_d  = bus.in_mode;
          k_d     = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (chunk_c != '0) begin
          number_d = number_c;
          zero_d   = 1'b0;
          state_d  = DONE;
        end else if (k_q == KW'(NCHUNK - 1)) begin
          number_d = '0;
          zero_d   = 1'b1;
          state_d  = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      mode_q   <= 1'b0;
      k_q      <= '0;
      number_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      mode_q   <= mode_d;
      k_q      <= k_d;
      number_q <= number_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_number = number_q;
  assign bus.out_zero   = zero_q;
endmodule

// File: tb/tb_log2_scan.sv
// Randomised self-checking bench for log2_scan against a bit-level reference
// model of index, zero flag, latency and handshake behaviour.
module tb_log2_scan;
  localparam int unsigned BIN_SIZE  = 32;
  localparam int unsigned BOUT_SIZE = 5;
  localparam int unsigned CHUNK     = 8;
  localparam int unsigned NCHUNK    = BIN_SIZE / CHUNK;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  log2_scan_if #(.BIN_SIZE(BIN_SIZE), .BOUT_SIZE(BOUT_SIZE)) bus ();

  log2_scan #(.BIN_SIZE(BIN_SIZE), .BOUT_SIZE(BOUT_SIZE), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: scan the whole vector bit by bit; latency from chunk position.
  task automatic ref_model(input logic [31:0] v, input logic m,
                           output int idx, output logic z, output int lat);
    idx = 0;
    z   = (v == 32'd0);
    if (!z) begin
      if (!m) begin
        for (int i = 0; i < 32; i++) if (v[i]) idx = i;
      end else begin
        for (int i = 31; i >= 0; i--) if (v[i]) idx = i;
      end
    end
    if (z) lat = NCHUNK + 1;
    else if (!m) lat = (NCHUNK - idx / CHUNK) + 1;
    else lat = (idx / CHUNK + 1) + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request: accept, scan with junk on the input side, hold result, handshake.
  task automatic run_req(input logic [31:0] v, input logic m, input int hold, input string tag);
    int   e_idx;
    logic e_zero;
    int   e_lat;
    int   cyc;
    ref_model(v, m, e_idx, e_zero, e_lat);
    check({tag, ":rdy_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_vector = v;
    bus.in_mode   = m;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    step();
    cyc = 1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && cyc < 64) begin
      check({tag, ":rdy_scan"}, 32'(bus.in_ready), 32'd0);
      bus.in_vector = $urandom;
      bus.in_mode   = 1'($urandom);
      bus.in_valid  = 1'($urandom);
      step();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check({tag, ":timeout"}, 32'(bus.out_valid), 32'd1);
    if (!bus.out_valid) return;
    check({tag, ":latency"}, 32'(cyc), 32'(e_lat));
    check({tag, ":number"}, 32'(bus.out_number), 32'(e_idx));
    check({tag, ":zero"}, 32'(bus.out_zero), 32'(e_zero));
    check({tag, ":rdy_done"}, 32'(bus.in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid  = 1'b1;
      bus.in_vector = $urandom;
      step();
      check({tag, ":hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ":hold_number"}, 32'(bus.out_number), 32'(e_idx));
      check({tag, ":hold_zero"}, 32'(bus.out_zero), 32'(e_zero));
      check({tag, ":hold_rdy"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, ":valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, ":rdy_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] v;
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_vector = '0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_number", 32'(bus.out_number), 32'd0);
    check("rst_zero", 32'(bus.out_zero), 32'd0);

    run_req(32'h0000_0001, 1'b0, 0, "t1");
    run_req(32'h8000_0001, 1'b0, 0, "t2_m0");
    run_req(32'h8000_0001, 1'b1, 0, "t2_m1");
    run_req(32'h0000_0000, 1'b0, 0, "t3_m0");
    run_req(32'h0000_0000, 1'b1, 1, "t3_m1");
    run_req(32'h0001_0000, 1'b1, 3, "t4");

    // Abort a request with reset in the middle of the scan.
    bus.in_vector = 32'h0000_0001;
    bus.in_mode   = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #2;
    check("t5_rst_rdy", 32'(bus.in_ready), 32'd1);
    check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_post_valid", 32'(bus.out_valid), 32'd0);
      check("t5_post_rdy", 32'(bus.in_ready), 32'd1);
    end
    bus.out_ready = 1'b0;
    run_req(32'h0000_0100, 1'b0, 0, "t5");

    for (int i = 0; i < 32; i++) begin
      run_req(32'(1) << i, 1'b0, 0, "onehot_m0");
      run_req(32'(1) << i, 1'b1, 0, "onehot_m1");
    end

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0:       v = $urandom;
        1:       v = $urandom & $urandom & $urandom & $urandom;
        default: v = ($urandom & 32'h0000_00ff) << (CHUNK * $urandom_range(0, NCHUNK - 1));
      endcase
      run_req(v, 1'($urandom), int'($urandom_range(0, 2)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
